video_stream_gen: RTL and testbench
===================================

Name: video_stream_gen

Overview:
- Generates a raster video stream (outvs/outde/outdata) of the format consumed by the window-tap blocks (array_tap and its 3x3/5x5 wrappers).
- Acts as the transmitter end of that stream interface: bench source, built-in self-test source and bring-up pattern generator.
- Blanking precedes active video on every line and in every frame. This matches the VIDEO_PRE_WIDTH convention of the tap blocks.

Parameters:
- DSIZE, 24: pixel data width.
- VIDEO_WIDTH, 1920: active pixels per line.
- VIDEO_PRE_WIDTH, 280: horizontal blanking cycles before the active pixels of each line.
- VIDEO_HEIGHT, 1080: active lines per frame.
- VIDEO_PRE_HEIGHT, 45: blanking lines before the active lines of each frame; must be at least VS_LINES.
- VS_LINES, 5: number of lines outvs is high, starting at line 0 of the frame.

Ports:
- clock, input, 1: sole clock.
- rst_n, input, 1: asynchronous reset, active low.
- enable, input, 1: run request.
- pattern_sel, input, 2: 0 = horizontal ramp, 1 = vertical ramp, 2 = 8x8 checkerboard, 3 = solid frame count.
- outvs, output, 1: vertical sync, active high.
- outde, output, 1: data enable, high on active pixels only.
- outdata, output, DSIZE: pixel value; zero whenever outde is low.
- frame_done, output, 1: one-cycle pulse coincident with the last active pixel of a frame.
- busy, output, 1: high while a frame is in progress.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE; h, v and frame_cnt are 0.
  - Reset takes effect immediately and mid-frame; no partial-frame completion after reset.
- Counters:
  - h runs 0 .. VIDEO_PRE_WIDTH+VIDEO_WIDTH-1 and wraps, incrementing v.
  - v runs 0 .. VIDEO_PRE_HEIGHT+VIDEO_HEIGHT-1.
  - Active region: h >= VIDEO_PRE_WIDTH and v >= VIDEO_PRE_HEIGHT.
  - x = h - VIDEO_PRE_WIDTH; y = v - VIDEO_PRE_HEIGHT.
- State machine:
  - IDLE -> RUN when enable is sampled high. h and v are 0 in the next cycle.
  - RUN -> RUN at the frame wrap if enable is high. A new frame starts with no gap cycles.
  - RUN -> IDLE at the frame wrap if enable is low. enable low mid-frame never truncates a frame.
  - RUN also moves to IDLE on reset.
- pattern_sel is sampled only when a frame starts (IDLE->RUN or frame wrap) and held for the whole frame.
- Output timing:
  - All outputs are registered, one cycle after the counter state they describe.
  - The first frame cycle (h=0, v=0) therefore appears on the outputs 2 cycles after enable is sampled high.
- outvs: high for the entire lines v < VS_LINES, including all h.
- outde: high for active (h, v) in RUN only.
- busy: high while in RUN.
- Pattern data (DSIZE bits, only while outde is high):
  - 0: x zero-extended or truncated to DSIZE.
  - 1: y zero-extended or truncated to DSIZE.
  - 2: all ones if x[3] XOR y[3], else all zeros.
  - 3: frame_cnt truncated to DSIZE.
- frame_cnt:
  - 16 bits, increments at each frame wrap or frame end, wraps at 0xFFFF.
  - The first frame after reset shows 0.
- frame_done: pulses on the same output cycle as the last active pixel (x = VIDEO_WIDTH-1, y = VIDEO_HEIGHT-1).
- Simultaneous events: enable falling on the last cycle of a frame is sampled at the wrap, so the block goes to IDLE. enable rising again in IDLE restarts with a 2-cycle latency.

Decomposition:
- Shared package video_pkg holds:
  - pattern codes PAT_HRAMP=0, PAT_VRAMP=1, PAT_CHECK=2, PAT_FCNT=3;
  - the frame counter width FCNT_W=16.
  - The tap blocks reuse the same package.
- One sub-module, video_timing_cnt: h/v counters, active/vs flags, frame wrap strobe, parameterised by the four geometry parameters.
- Pattern muxing and output registers stay in the top level.

Test Plan:
Common setup for all scenarios: VIDEO_WIDTH=8, VIDEO_PRE_WIDTH=4, VIDEO_HEIGHT=4, VIDEO_PRE_HEIGHT=2, VS_LINES=1, DSIZE=24. This gives a 12-cycle line and a 72-cycle frame.
- Basic frame, pattern 0:
  - Stimulus: enable held high for one frame.
  - Required: outde is first high 2+2*12+4 = 30 cycles after enable is sampled, with outdata 0..7 per line.
  - Required: 32 outde cycles per frame.
  - Required: outvs high for exactly 12 cycles starting at the first frame cycle.
- Back-to-back frames, pattern 3:
  - Stimulus: enable held high for 3 frames.
  - Required: outdata is 0, 1, 2 on the active pixels of frames 0, 1, 2.
  - Required: frame period is exactly 72 cycles; frame_done pulses 3 times, each on the last outde cycle.
- Mid-frame stop:
  - Stimulus: deassert enable in cycle 20 of a frame.
  - Required: the frame completes (32 outde cycles); busy drops after the final wrap; outvs and outde stay 0 afterwards.
- Pattern change mid-frame:
  - Stimulus: pattern_sel changes 0 -> 2 mid-frame.
  - Required: the current frame stays a ramp.
  - Required: the next frame shows a checkerboard with y=0, x=0..7 equal to 0x000000 x8. With width 8 and x[3]=0, all pixels read 0 for y<4.
  - Required: pattern 1 in the next frame shows lines 0, 1, 2, 3.
- Async reset mid-frame:
  - Stimulus: rst_n low for a half cycle during an active line.
  - Required: all outputs 0 immediately; with enable still high, restart yields a full frame with frame_cnt=0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the raster video stream: pattern codes and frame counter width.
// Reused by the window-tap blocks that consume this stream.
package video_pkg;

   localparam int FCNT_W = 16;

   typedef enum logic [1:0] {
      PAT_HRAMP = 2'd0,
      PAT_VRAMP = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_FCNT  = 2'd3
   } pattern_e;

endpackage

// File: rtl/video_timing_cnt.sv
// Raster h/v position counters with active-region, vsync and end-of-frame flags.
// Counters are held at the origin while run_i is low so a new frame starts at (0,0).
module video_timing_cnt #(
   parameter int VIDEO_WIDTH      = 1920,
   parameter int VIDEO_PRE_WIDTH  = 280,
   parameter int VIDEO_HEIGHT     = 1080,
   parameter int VIDEO_PRE_HEIGHT = 45,
   parameter int VS_LINES         = 5,
   localparam int HW = $clog2(VIDEO_PRE_WIDTH + VIDEO_WIDTH),
   localparam int VW = $clog2(VIDEO_PRE_HEIGHT + VIDEO_HEIGHT)
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          run_i,
   output logic [HW-1:0] h_o,
   output logic [VW-1:0] v_o,
   output logic          active_o,
   output logic          vs_o,
   output logic          wrap_o
);

   localparam logic [HW-1:0] H_LAST = HW'(VIDEO_PRE_WIDTH + VIDEO_WIDTH - 1);
   localparam logic [VW-1:0] V_LAST = VW'(VIDEO_PRE_HEIGHT + VIDEO_HEIGHT - 1);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          h_last, v_last;

   assign h_last = (h_q == H_LAST);
   assign v_last = (v_q == V_LAST);

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (!run_i) begin
         h_d = '0;
         v_d = '0;
      end else if (h_last) begin
         h_d = '0;
         v_d = v_last ? '0 : v_q + VW'(1);
      end else begin
         h_d = h_q + HW'(1);
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h_o      = h_q;
   assign v_o      = v_q;
   assign active_o = (h_q >= HW'(VIDEO_PRE_WIDTH)) && (v_q >= VW'(VIDEO_PRE_HEIGHT));
   assign vs_o     = (v_q < VW'(VS_LINES));
   assign wrap_o   = h_last && v_last;

endmodule

// File: rtl/video_stream_gen.sv
// Raster video stream source (vs/de/data) with selectable test patterns and frame counter.
// All outputs are registered one cycle after the counter state they describe.
//
// state | meaning
// IDLE  | counters parked at (0,0), outputs quiet, waiting for enable
// RUN   | frame in progress; at the frame wrap either restart (enable) or stop
module video_stream_gen
   import video_pkg::*;
#(
   parameter int DSIZE            = 24,
   parameter int VIDEO_WIDTH      = 1920,
   parameter int VIDEO_PRE_WIDTH  = 280,
   parameter int VIDEO_HEIGHT     = 1080,
   parameter int VIDEO_PRE_HEIGHT = 45,
   parameter int VS_LINES         = 5
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [1:0]       pattern_sel,
   output logic             outvs,
   output logic             outde,
   output logic [DSIZE-1:0] outdata,
   output logic             frame_done,
   output logic             busy
);

   localparam int HW = $clog2(VIDEO_PRE_WIDTH + VIDEO_WIDTH);
   localparam int VW = $clog2(VIDEO_PRE_HEIGHT + VIDEO_HEIGHT);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state_q, state_d;
   pattern_e          pat_q, pat_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              frame_start, run;

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          active, vs, wrap;
   logic [31:0]   x_w, y_w;
   logic [DSIZE-1:0] pix;

   assign run = (state_q == ST_RUN);

   video_timing_cnt #(
      .VIDEO_WIDTH      (VIDEO_WIDTH),
      .VIDEO_PRE_WIDTH  (VIDEO_PRE_WIDTH),
      .VIDEO_HEIGHT     (VIDEO_HEIGHT),
      .VIDEO_PRE_HEIGHT (VIDEO_PRE_HEIGHT),
      .VS_LINES         (VS_LINES)
   ) u_timing (
      .clock    (clock),
      .rst_n    (rst_n),
      .run_i    (run),
      .h_o      (h),
      .v_o      (v),
      .active_o (active),
      .vs_o     (vs),
      .wrap_o   (wrap)
   );

   // The frame counter advances on every completed frame, whether or not another follows.
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      fcnt_d      = fcnt_q;
      frame_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d     = ST_RUN;
               frame_start = 1'b1;
            end
         end
         default: begin
            if (wrap) begin
               fcnt_d = fcnt_q + FCNT_W'(1);
               if (enable) frame_start = 1'b1;
               else        state_d     = ST_IDLE;
            end
         end
      endcase
      if (frame_start) pat_d = pattern_e'(pattern_sel);
   end

   assign x_w = 32'(h) - 32'(VIDEO_PRE_WIDTH);
   assign y_w = 32'(v) - 32'(VIDEO_PRE_HEIGHT);

   always_comb begin
      pix = '0;
      case (pat_q)
         PAT_HRAMP: pix = DSIZE'(x_w);
         PAT_VRAMP: pix = DSIZE'(y_w);
         PAT_CHECK: pix = (x_w[3] ^ y_w[3]) ? '1 : '0;
         PAT_FCNT:  pix = DSIZE'(fcnt_q);
         default:   pix = '0;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pat_q      <= PAT_HRAMP;
         fcnt_q     <= '0;
         outvs      <= 1'b0;
         outde      <= 1'b0;
         outdata    <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         pat_q      <= pat_d;
         fcnt_q     <= fcnt_d;
         outvs      <= run && vs;
         outde      <= run && active;
         outdata    <= (run && active) ? pix : '0;
         frame_done <= run && wrap;
         busy       <= run;
      end
   end

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen on a 12x6 raster (8x4 active, 72-cycle frame).
module tb_video_stream_gen;

   localparam int DSIZE = 24;
   localparam int FRAME = 72;

   logic             clock = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic [1:0]       pattern_sel = 2'd0;
   logic             outvs, outde, frame_done, busy;
   logic [DSIZE-1:0] outdata;

   always #5 clock = ~clock;

   video_stream_gen #(
      .DSIZE            (DSIZE),
      .VIDEO_WIDTH      (8),
      .VIDEO_PRE_WIDTH  (4),
      .VIDEO_HEIGHT     (4),
      .VIDEO_PRE_HEIGHT (2),
      .VS_LINES         (1)
   ) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .outvs       (outvs),
      .outde       (outde),
      .outdata     (outdata),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   typedef struct {
      string      name;
      logic [1:0] pat;
      int         chg_k;
      logic [1:0] pat_next;
      int         drop_k;
      int         n_cyc;
      int         nf;
   } vec_t;

   vec_t vecs[5];

   int n_vec = 0;
   int n_err = 0;

   logic [DSIZE-1:0] pix[$];
   int fd_k[$];
   int de_cnt, first_de, vs_cnt, vs_first, fd_cnt, fd_bad, zero_bad, last_busy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst_n  = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   function automatic logic [DSIZE-1:0] exp_pix(input logic [1:0] p, input int x, input int y, input int f);
      case (p)
         2'd0:    return DSIZE'(x);
         2'd1:    return DSIZE'(y);
         2'd2:    return (((x ^ y) & 8) != 0) ? {DSIZE{1'b1}} : '0;
         default: return DSIZE'(f);
      endcase
   endfunction

   // k counts posedges after enable is driven; outputs are sampled 1 ns after each edge.
   task automatic run_seq(input logic [1:0] pat, input int chg_k, input logic [1:0] pat_next,
                          input int drop_k, input int n_cyc);
      pix.delete();
      fd_k.delete();
      de_cnt = 0; first_de = -1; vs_cnt = 0; vs_first = -1;
      fd_cnt = 0; fd_bad = 0; zero_bad = 0; last_busy = -1;
      pattern_sel = pat;
      enable      = 1'b1;
      for (int k = 1; k <= n_cyc; k++) begin
         step();
         if (outde) begin
            de_cnt++;
            if (first_de < 0) first_de = k;
            pix.push_back(outdata);
         end else if (outdata != '0) begin
            zero_bad++;
         end
         if (outvs) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = k;
         end
         if (frame_done) begin
            fd_cnt++;
            fd_k.push_back(k);
            if (!outde || (pix.size() % 32) != 0) fd_bad++;
         end
         if (busy) last_busy = k;
         if (k == chg_k)  pattern_sel = pat_next;
         if (k == drop_k) enable = 1'b0;
      end
   endtask

   task automatic check_run(input string nm, input logic [1:0] pat, input logic [1:0] pat_next, input int nf);
      chk({nm, " de_count"}, de_cnt, 32 * nf);
      chk({nm, " first_de"}, first_de, 30);
      chk({nm, " vs_count"}, vs_cnt, 12 * nf);
      chk({nm, " vs_first"}, vs_first, 2);
      chk({nm, " fd_count"}, fd_cnt, nf);
      chk({nm, " fd_on_last_pixel"}, fd_bad, 0);
      chk({nm, " data_zero_outside_de"}, zero_bad, 0);
      chk({nm, " busy_last"}, last_busy, FRAME * nf + 1);
      chk({nm, " end_outvs"}, outvs, 0);
      chk({nm, " end_outde"}, outde, 0);
      chk({nm, " end_busy"}, busy, 0);
      for (int i = 0; i < fd_k.size(); i++)
         chk($sformatf("%s fd_time[%0d]", nm, i), fd_k[i], 73 + FRAME * i);
      for (int j = 0; j < pix.size() && j < 32 * nf; j++) begin
         int f = j / 32;
         chk($sformatf("%s pix f%0d y%0d x%0d", nm, f, (j % 32) / 8, j % 8),
             32'(pix[j]), 32'(exp_pix((f == 0) ? pat : pat_next, j % 8, (j % 32) / 8, f)));
      end
   endtask

   initial begin
      vecs[0] = '{"basic_hramp",  2'd0, -1, 2'd0,  60,  90, 1};
      vecs[1] = '{"b2b_fcnt",     2'd3, -1, 2'd3, 150, 230, 3};
      vecs[2] = '{"midframe_stop",2'd0, -1, 2'd0,  20,  90, 1};
      vecs[3] = '{"chg_to_check", 2'd0, 40, 2'd2, 100, 160, 2};
      vecs[4] = '{"chg_to_vramp", 2'd0, 40, 2'd1, 100, 160, 2};

      step();
      step();
      chk("reset outvs", outvs, 0);
      chk("reset outde", outde, 0);
      chk("reset outdata", 32'(outdata), 0);
      chk("reset frame_done", frame_done, 0);
      chk("reset busy", busy, 0);

      foreach (vecs[i]) begin
         do_reset();
         run_seq(vecs[i].pat, vecs[i].chg_k, vecs[i].pat_next, vecs[i].drop_k, vecs[i].n_cyc);
         check_run(vecs[i].name, vecs[i].pat, vecs[i].pat_next, vecs[i].nf);
      end

      // Async reset during an active line of the second frame, enable left high.
      do_reset();
      pattern_sel = 2'd3;
      enable      = 1'b1;
      for (int k = 1; k <= 108; k++) step();
      chk("pre_reset outde", outde, 1);
      chk("pre_reset outdata", 32'(outdata), 1);
      rst_n = 1'b0;
      #2;
      chk("async outvs", outvs, 0);
      chk("async outde", outde, 0);
      chk("async outdata", 32'(outdata), 0);
      chk("async frame_done", frame_done, 0);
      chk("async busy", busy, 0);
      #3;
      rst_n = 1'b1;
      run_seq(2'd3, -1, 2'd3, 60, 90);
      check_run("rst_restart", 2'd3, 2'd3, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
